// File: rtl/answer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : answer_pkg
// Brief    : Shared constants, FSM state encoding and nibble helpers for answer_ctrl
// Revision : 1.0
// ============================================================================
package answer_pkg;

    localparam int NIB_W       = 4;
    localparam int MAX_DIGITS  = 8;
    localparam int DIG_MIN_DEF = 1;
    localparam int DIG_MAX_DEF = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_FAIL  = 3'd5;

    // Ones over the low n nibbles, zero above.
    function automatic logic [31:0] nib_mask(input int n);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (k < n) m[k*NIB_W +: NIB_W] = '1;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/answer_digit_check.sv
`default_nettype none
// ============================================================================
// Module   : answer_digit_check
// Brief    : Rejects nibble idx_i if out of range or equal to any lower nibble
// Revision : 1.0
// ============================================================================
module answer_digit_check
    import answer_pkg::*;
#(
    parameter int DIG_MIN = DIG_MIN_DEF,
    parameter int DIG_MAX = DIG_MAX_DEF
) (
    input  logic [31:0] word_i,
    input  logic [2:0]  idx_i,
    output logic        reject_o
);

    localparam logic [NIB_W-1:0] LO = NIB_W'(DIG_MIN);
    localparam logic [NIB_W-1:0] HI = NIB_W'(DIG_MAX);

    logic [NIB_W-1:0] nib [MAX_DIGITS];
    logic [NIB_W-1:0] dig;

    always_comb begin
        for (int j = 0; j < MAX_DIGITS; j++) begin
            nib[j] = word_i[j*NIB_W +: NIB_W];
        end
    end

    always_comb begin
        dig      = nib[idx_i];
        reject_o = (dig < LO) || (dig > HI);
        for (int j = 0; j < MAX_DIGITS; j++) begin
            if ((3'(j) < idx_i) && (nib[j] == dig)) reject_o = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/answer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : answer_ctrl
// Brief    : Draws random words until one has NUM_DIGITS distinct in-range digits
// Revision : 1.0
// ============================================================================
module answer_ctrl
    import answer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_RETRY  = 15,
    parameter int TIMEOUT    = 1023,
    parameter int DIG_MIN    = DIG_MIN_DEF,
    parameter int DIG_MAX    = DIG_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic [31:0] rand_in,
    input  logic        rand_valid,
    output logic        change_answer,
    output logic [31:0] answer,
    output logic        answer_valid,
    output logic        busy,
    output logic [3:0]  retry_cnt,
    output logic        fail
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]       RETRY_MX = 4'(MAX_RETRY);
    localparam logic [31:0]      MASK     = nib_mask(NUM_DIGITS);

    state_t            state_q, state_d;
    logic [3:0]        retry_q, retry_d;
    logic [TMO_W-1:0]  tmo_q,   tmo_d;
    logic [2:0]        idx_q,   idx_d;
    logic [31:0]       cap_q,   cap_d;
    logic              rej_q,   rej_d;
    logic [31:0]       ans_q,   ans_d;
    logic              ansv_q,  ansv_d;
    logic              fail_q,  fail_d;
    logic              dig_rej;
    logic              draw_rej;

    answer_digit_check #(
        .DIG_MIN (DIG_MIN),
        .DIG_MAX (DIG_MAX)
    ) u_digit_check (
        .word_i   (cap_q),
        .idx_i    (idx_q),
        .reject_o (dig_rej)
    );

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        tmo_d    = tmo_q;
        idx_d    = idx_q;
        cap_d    = cap_q;
        rej_d    = rej_q;
        ans_d    = ans_q;
        ansv_d   = ansv_q;
        fail_d   = fail_q;
        draw_rej = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (new_game) begin
                    state_d = ST_REQ;
                    retry_d = '0;
                    fail_d  = 1'b0;
                    ansv_d  = 1'b0;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                tmo_d   = '0;
            end
            ST_WAIT: begin
                if (rand_valid) begin
                    cap_d   = rand_in;
                    tmo_d   = '0;
                    idx_d   = '0;
                    rej_d   = 1'b0;
                    state_d = ST_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d    = '0;
                    draw_rej = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CHECK: begin
                // Every digit gets its own cycle, so a rejection is only acted on at the end.
                if (idx_q == LAST_IDX) begin
                    if (rej_q || dig_rej) begin
                        draw_rej = 1'b1;
                    end else begin
                        ans_d   = cap_q & MASK;
                        ansv_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                    rej_d = rej_q || dig_rej;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (draw_rej) begin
            if (retry_q < RETRY_MX) begin
                retry_d = retry_q + 4'd1;
                state_d = ST_REQ;
            end else begin
                state_d = ST_FAIL;
                fail_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            retry_q <= '0;
            tmo_q   <= '0;
            idx_q   <= '0;
            cap_q   <= '0;
            rej_q   <= 1'b0;
            ans_q   <= '0;
            ansv_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            rej_q   <= rej_d;
            ans_q   <= ans_d;
            ansv_q  <= ansv_d;
            fail_q  <= fail_d;
        end
    end

    assign change_answer = (state_q == ST_REQ);
    assign busy          = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign answer        = ans_q;
    assign answer_valid  = ansv_q;
    assign retry_cnt     = retry_q;
    assign fail          = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_answer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_answer_ctrl
// Brief    : Directed self-checking bench for answer_ctrl (MAX_RETRY=2, TIMEOUT=8)
// Revision : 1.0
// ============================================================================
module tb_answer_ctrl;

    localparam int NUM_DIGITS = 4;

    logic        clk;
    logic        rst_n;
    logic        new_game;
    logic [31:0] rand_in;
    logic        rand_valid;
    logic        change_answer;
    logic [31:0] answer;
    logic        answer_valid;
    logic        busy;
    logic [3:0]  retry_cnt;
    logic        fail;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int p0;

    answer_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .MAX_RETRY  (2),
        .TIMEOUT    (8),
        .DIG_MIN    (1),
        .DIG_MAX    (8)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .new_game      (new_game),
        .rand_in       (rand_in),
        .rand_valid    (rand_valid),
        .change_answer (change_answer),
        .answer        (answer),
        .answer_valid  (answer_valid),
        .busy          (busy),
        .retry_cnt     (retry_cnt),
        .fail          (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && change_answer) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " answer"},        answer,               32'h0);
        chk({tag, " answer_valid"},  {31'b0, answer_valid}, 32'h0);
        chk({tag, " change_answer"}, {31'b0, change_answer}, 32'h0);
        chk({tag, " busy"},          {31'b0, busy},         32'h0);
        chk({tag, " retry_cnt"},     {28'b0, retry_cnt},    32'h0);
        chk({tag, " fail"},          {31'b0, fail},         32'h0);
    endtask

    // Called in the REQ cycle; returns after the last CHECK edge.
    task automatic draw(input logic [31:0] w);
        tick();
        rand_valid = 1'b1;
        rand_in    = w;
        tick();
        rand_valid = 1'b0;
        rand_in    = 32'hFFFF_FFFF;
        repeat (NUM_DIGITS) tick();
    endtask

    task automatic start_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        new_game   = 1'b0;
        rand_in    = 32'h0;
        rand_valid = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();
        chk_zero("idle");

        // Clean draw: rand_valid two cycles after change_answer
        p0 = pulses;
        start_game();
        chk("clean req strobe", {31'b0, change_answer}, 32'h1);
        chk("clean busy",       {31'b0, busy},          32'h1);
        tick();
        tick();
        rand_valid = 1'b1;
        rand_in    = 32'h8765_4321;
        tick();
        rand_valid = 1'b0;
        rand_in    = 32'hFFFF_FFFF;
        repeat (NUM_DIGITS - 1) tick();
        chk("clean not yet valid", {31'b0, answer_valid}, 32'h0);
        tick();
        chk("clean answer",    answer,                    32'h0000_4321);
        chk("clean valid",     {31'b0, answer_valid},     32'h1);
        chk("clean retry",     {28'b0, retry_cnt},        32'h0);
        chk("clean idle busy", {31'b0, busy},             32'h0);
        chk("clean pulses",    32'(pulses - p0),          32'h1);
        rand_valid = 1'b1;
        rand_in    = 32'h0000_5555;
        repeat (2) tick();
        rand_valid = 1'b0;
        chk("done hold answer", answer,                32'h0000_4321);
        chk("done hold valid",  {31'b0, answer_valid}, 32'h1);

        // Duplicate digit then good draw
        p0 = pulses;
        start_game();
        chk("dup valid cleared", {31'b0, answer_valid}, 32'h0);
        draw(32'h0000_1121);
        chk("dup re-request", {31'b0, change_answer}, 32'h1);
        chk("dup retry",      {28'b0, retry_cnt},     32'h1);
        chk("dup answer kept", answer,                32'h0000_4321);
        draw(32'h0000_3412);
        chk("dup answer", answer,                32'h0000_3412);
        chk("dup valid",  {31'b0, answer_valid}, 32'h1);
        chk("dup retry2", {28'b0, retry_cnt},    32'h1);
        chk("dup pulses", 32'(pulses - p0),      32'h2);

        // Out-of-range digits (0 and 9), then a draw using both range ends
        start_game();
        tick();
        rand_valid = 1'b1;
        rand_in    = 32'h0000_0921;
        tick();
        rand_valid = 1'b0;
        new_game   = 1'b1;
        tick();
        new_game   = 1'b0;
        repeat (NUM_DIGITS - 1) tick();
        chk("range re-request", {31'b0, change_answer}, 32'h1);
        chk("range retry",      {28'b0, retry_cnt},     32'h1);
        draw(32'h0000_8671);
        chk("range answer", answer,                32'h0000_8671);
        chk("range valid",  {31'b0, answer_valid}, 32'h1);

        // Retry exhaustion with MAX_RETRY=2
        p0 = pulses;
        start_game();
        draw(32'h0000_1111);
        chk("exh retry1", {28'b0, retry_cnt}, 32'h1);
        draw(32'h0000_1111);
        chk("exh retry2", {28'b0, retry_cnt}, 32'h2);
        draw(32'h0000_1111);
        chk("exh fail",   {31'b0, fail},         32'h1);
        chk("exh busy",   {31'b0, busy},         32'h0);
        chk("exh valid",  {31'b0, answer_valid}, 32'h0);
        chk("exh retry3", {28'b0, retry_cnt},    32'h2);
        repeat (3) tick();
        chk("exh pulses", 32'(pulses - p0),      32'h3);
        chk("exh fail held", {31'b0, fail},      32'h1);

        // Timeout with TIMEOUT=8
        start_game();
        chk("tmo fail cleared",  {31'b0, fail},      32'h0);
        chk("tmo retry cleared", {28'b0, retry_cnt}, 32'h0);
        tick();
        repeat (7) tick();
        chk("tmo still waiting", {31'b0, change_answer}, 32'h0);
        chk("tmo busy",          {31'b0, busy},          32'h1);
        tick();
        chk("tmo re-request", {31'b0, change_answer}, 32'h1);
        chk("tmo retry",      {28'b0, retry_cnt},     32'h1);

        // Reset in WAIT, then a late rand_valid
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        rand_valid = 1'b1;
        rand_in    = 32'h0000_4321;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        rand_valid = 1'b0;
        repeat (NUM_DIGITS + 1) tick();
        chk_zero("late valid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/answer_ctrl.md
ANSWER_CTRL -- requirements
Module: answer_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of answer digits (1..8), taken from the low nibbles of the random word.
REQ-002 SHALL have parameter MAX_RETRY, default 15, meaning the number of rejected draws after which the controller reports failure.
REQ-003 SHALL have parameter TIMEOUT, default 1023, meaning the number of cycles to wait for rand_valid before a draw counts as rejected.
REQ-004 SHALL have parameters DIG_MIN, default 1, and DIG_MAX, default 8, meaning the inclusive legal digit range.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port new_game, input, 1 bit: single-cycle request for a fresh answer.
REQ-008 SHALL have port rand_in, input, 32 bits: candidate word from the random generator.
REQ-009 SHALL have port rand_valid, input, 1 bit: rand_in is fresh (the generator's write strobe).
REQ-010 SHALL have port change_answer, output, 1 bit: one-cycle draw request to the generator.
REQ-011 SHALL have port answer, output, 32 bits: committed answer; bits above 4*NUM_DIGITS are zero.
REQ-012 SHALL have port answer_valid, output, 1 bit: answer holds a checked value.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE, DONE and FAIL.
REQ-014 SHALL have port retry_cnt, output, 4 bits: rejected draws in the current game.
REQ-015 SHALL have port fail, output, 1 bit: retry limit reached.

Function
REQ-016 SHALL implement the states IDLE, REQ, WAIT, CHECK, DONE and FAIL.
REQ-017 SHALL, on new_game in IDLE, DONE or FAIL, move to REQ on the next edge; clear retry_cnt, fail and answer_valid; and leave answer unchanged.
REQ-018 SHALL ignore new_game in REQ, WAIT and CHECK.
REQ-019 SHALL hold change_answer high for exactly the one cycle spent in REQ, then move to WAIT.
REQ-020 SHALL, in WAIT, capture rand_in when rand_valid is high, clear the timeout counter and move to CHECK.
REQ-021 SHALL ignore rand_valid in every state other than WAIT.
REQ-022 SHALL, in WAIT, count a timeout after TIMEOUT cycles with no rand_valid and treat it as a rejected draw.
REQ-023 SHALL spend exactly NUM_DIGITS cycles in CHECK, testing digit i (nibble i) in cycle i.
REQ-024 SHALL reject digit i if it lies outside DIG_MIN..DIG_MAX or equals any digit j with j<i.
REQ-025 SHALL, if the check passes, load answer with the masked captured word, set answer_valid and move to DONE.
REQ-026 SHALL, on a rejected draw with retry_cnt < MAX_RETRY, increment retry_cnt and return to REQ.
REQ-027 SHALL, on a rejected draw with retry_cnt == MAX_RETRY, move to FAIL and set fail.
REQ-028 SHALL saturate retry_cnt and never wrap it.
REQ-029 SHALL give a minimum latency from new_game to answer_valid of 3 + (cycles until rand_valid) + NUM_DIGITS edges.
REQ-030 SHALL keep answer and answer_valid stable in DONE until the next accepted new_game.

Reset
REQ-031 SHALL, on rst_n low, immediately enter IDLE with answer=0, answer_valid=0, change_answer=0, busy=0, retry_cnt=0, fail=0 and all counters cleared.
REQ-032 SHALL abandon any draw in progress when reset is asserted mid-operation; a rand_valid arriving after reset release while in IDLE is ignored.
REQ-033 SHALL release from reset synchronously to clk; the first state change is possible on the first rising edge with rst_n high.

Structure
REQ-034 SHALL place the state enumeration, the digit range constants and the nibble-width constant in a shared package (answer_pkg).
REQ-035 SHALL implement the per-digit range and duplicate test as one combinational sub-module, answer_digit_check (inputs: captured word and digit index; output: reject).

Verification
REQ-036 SHALL cover a clean draw: new_game, then rand_valid two cycles after change_answer with rand_in=0x87654321 -> answer=0x00004321, answer_valid=1, retry_cnt=0, exactly one change_answer pulse.
REQ-037 SHALL cover a duplicate digit: first draw 0x00001121, second draw 0x00003412 -> one reject, second change_answer pulse, answer=0x00003412, retry_cnt=1.
REQ-038 SHALL cover an out-of-range digit: draw 0x00000921 -> rejected (digit 0 fails and digit 9 fails), retry follows.
REQ-039 SHALL cover retry exhaustion: MAX_RETRY=2 with every draw 0x00001111 -> three change_answer pulses, then fail=1, busy=0, answer_valid=0.
REQ-040 SHALL cover a timeout: TIMEOUT=8 with no rand_valid -> re-request after 8 WAIT cycles and retry_cnt=1.
REQ-041 SHALL cover reset in WAIT followed by a late rand_valid: all outputs zero, state IDLE, no answer loaded.
